// File: rtl/fpga_cfg_loader_if.sv
// FTDI 245 synchronous-FIFO receive bus between the USB bridge (master) and the loader (slave).
interface fpga_cfg_loader_if;
  logic [7:0] ftdi_data;
  logic       ftdi_rxf_n;
  logic       ftdi_rd_n;

  modport master (output ftdi_data, output ftdi_rxf_n, input ftdi_rd_n);
  modport slave  (input ftdi_data, input ftdi_rxf_n, output ftdi_rd_n);
endinterface

// File: rtl/fpga_cfg_loader.sv
// CPLD bootloader: FTDI FIFO -> byte buffer -> FPGA slave-serial/parallel configuration sequencer.
// Optional byte counter port bytes_loaded is enabled by defining BYTE_CNT_EN.
module fpga_cfg_loader #(
  parameter int BUS_W        = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLK_DIV      = 1,
  parameter int PROG_CYCLES  = 32,
  parameter int INIT_TIMEOUT = 4096,
  parameter int STARTUP_CLKS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  fpga_cfg_loader_if.slave  ftdi,
  input  logic              ftdi_gpio_0,
  input  logic              ftdi_gpio_1,
  output logic              fpga_program_b,
  input  logic              fpga_init_b,
  input  logic              fpga_done,
  output logic              fpga_bl_clk,
  output logic [BUS_W-1:0]  fpga_bl_data,
  output logic              busy,
  output logic              cfg_ok,
  output logic              cfg_err
`ifdef BYTE_CNT_EN
  ,
  output logic [23:0]       bytes_loaded
`endif
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int PULSES = 8 / BUS_W;
  localparam int TMAX0  = (PROG_CYCLES > INIT_TIMEOUT) ? PROG_CYCLES : INIT_TIMEOUT;
  localparam int TMAX   = (TMAX0 > STARTUP_CLKS) ? TMAX0 : STARTUP_CLKS;
  localparam int TW     = $clog2(TMAX + 1) + 1;
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PROG      = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_LOAD      = 3'd3,
    ST_STARTUP   = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } state_t;

  state_t          state_r, next_state_s;
  logic            init_meta_r, init_sync_r, done_meta_r, done_sync_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_nxt_s;
  logic [7:0]      shift_r;
  logic            active_r, bl_clk_r;
  logic [3:0]      pulses_r;
  logic [DW-1:0]   div_r;
  logic [TW-1:0]   timer_r;
  logic            program_b_r, rd_n_r, busy_r, ok_r, err_r;
  logic            program_b_s, rd_n_s, busy_s, ok_s, err_s;
  logic            mode_prog_s, mode_stream_s, in_load_s, stay_load_s;
  logic            tick_s, fall_s, wr_s, word_end_s, pop_s;

  assign mode_prog_s   = ftdi_gpio_1 & ftdi_gpio_0;
  assign mode_stream_s = ftdi_gpio_1 & ~ftdi_gpio_0;
  assign in_load_s     = (state_r == ST_LOAD);
  assign stay_load_s   = in_load_s && (next_state_s == ST_LOAD);
  assign tick_s        = (div_r == DW'(CLK_DIV - 1));
  assign fall_s        = bl_clk_r && tick_s;
  assign wr_s          = in_load_s && !ftdi.ftdi_rxf_n && !rd_n_r;
  assign word_end_s    = active_r && fall_s && (pulses_r == 4'd1);
  // A new word is taken either into an idle shifter or on the falling edge that ends the current one.
  assign pop_s         = in_load_s && (count_r != '0) && (!active_r || word_end_s);

  assign fpga_program_b = program_b_r;
  assign ftdi.ftdi_rd_n = rd_n_r;
  assign fpga_bl_clk    = bl_clk_r;
  assign fpga_bl_data   = shift_r[7 -: BUS_W];
  assign busy           = busy_r;
  assign cfg_ok         = ok_r;
  assign cfg_err        = err_r;

  // Two-flop synchronisers for the FPGA status pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_meta_r <= 1'b0;
      init_sync_r <= 1'b0;
      done_meta_r <= 1'b0;
      done_sync_r <= 1'b0;
    end else begin
      init_meta_r <= fpga_init_b;
      init_sync_r <= init_meta_r;
      done_meta_r <= fpga_done;
      done_sync_r <= done_meta_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; program mode preempts every state.
  always_comb begin
    next_state_s = state_r;
    if (mode_prog_s && (state_r != ST_PROG)) begin
      next_state_s = ST_PROG;
    end else begin
      case (state_r)
        ST_PROG: begin
          if (!mode_prog_s && (timer_r >= TW'(PROG_CYCLES - 1))) next_state_s = ST_WAIT_INIT;
          else next_state_s = ST_PROG;
        end
        ST_WAIT_INIT: begin
          if (init_sync_r) next_state_s = ST_LOAD;
          else if (timer_r >= TW'(INIT_TIMEOUT - 1)) next_state_s = ST_ERROR;
          else next_state_s = ST_WAIT_INIT;
        end
        ST_LOAD: begin
          if (!init_sync_r) next_state_s = ST_ERROR;
          else if (!mode_stream_s && (count_r == '0) && !active_r && !bl_clk_r && !wr_s)
            next_state_s = ST_STARTUP;
          else next_state_s = ST_LOAD;
        end
        ST_STARTUP: begin
          if (!init_sync_r) next_state_s = ST_ERROR;
          else if (timer_r == TW'(STARTUP_CLKS)) next_state_s = done_sync_r ? ST_DONE : ST_ERROR;
          else next_state_s = ST_STARTUP;
        end
        ST_IDLE, ST_DONE, ST_ERROR: next_state_s = state_r;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Occupancy after this edge; zero whenever the buffer is flushed.
  always_comb begin
    count_nxt_s = '0;
    if (stay_load_s) count_nxt_s = count_r + CW'(wr_s) - CW'(pop_s);
    else count_nxt_s = '0;
  end

  // Output decode from the state being entered, so every output leaves a flop.
  always_comb begin
    program_b_s = 1'b1;
    busy_s      = 1'b0;
    rd_n_s      = 1'b1;
    ok_s        = ok_r;
    err_s       = err_r;
    case (next_state_s)
      ST_PROG: begin
        program_b_s = 1'b0;
        busy_s      = 1'b1;
      end
      ST_WAIT_INIT, ST_STARTUP: busy_s = 1'b1;
      ST_LOAD: begin
        busy_s = 1'b1;
        rd_n_s = !(mode_stream_s && (count_nxt_s < CW'(FIFO_DEPTH)));
      end
      default: busy_s = 1'b0;
    endcase
    if ((next_state_s == ST_PROG) && (state_r != ST_PROG)) begin
      ok_s  = 1'b0;
      err_s = 1'b0;
    end else if ((next_state_s == ST_DONE) && (state_r != ST_DONE)) begin
      ok_s = 1'b1;
    end else if ((next_state_s == ST_ERROR) && (state_r != ST_ERROR)) begin
      err_s = 1'b1;
    end else begin
      ok_s  = ok_r;
      err_s = err_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      program_b_r <= 1'b1;
      rd_n_r      <= 1'b1;
      busy_r      <= 1'b0;
      ok_r        <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      program_b_r <= program_b_s;
      rd_n_r      <= rd_n_s;
      busy_r      <= busy_s;
      ok_r        <= ok_s;
      err_r       <= err_s;
    end
  end

  // Byte buffer storage.
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[wr_ptr_r] <= ftdi.ftdi_data;
  end

  // Byte buffer pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (!stay_load_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      count_r <= count_nxt_s;
    end
  end

  // Shifter, configuration clock generator and per-state timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r  <= 8'h00;
      active_r <= 1'b0;
      pulses_r <= 4'd0;
      div_r    <= '0;
      bl_clk_r <= 1'b0;
      timer_r  <= '0;
    end else if (next_state_s != state_r) begin
      shift_r  <= (next_state_s == ST_STARTUP) ? 8'hFF : 8'h00;
      active_r <= 1'b0;
      pulses_r <= 4'd0;
      div_r    <= '0;
      bl_clk_r <= 1'b0;
      timer_r  <= '0;
    end else if (state_r == ST_LOAD) begin
      if (pop_s) begin
        shift_r  <= mem_r[rd_ptr_r];
        active_r <= 1'b1;
        pulses_r <= 4'(PULSES);
        div_r    <= '0;
        bl_clk_r <= 1'b0;
      end else if (active_r && tick_s) begin
        div_r    <= '0;
        bl_clk_r <= !bl_clk_r;
        if (word_end_s) begin
          active_r <= 1'b0;
        end else if (fall_s) begin
          shift_r  <= shift_r << BUS_W;
          pulses_r <= pulses_r - 4'd1;
        end
      end else if (active_r) begin
        div_r <= div_r + 1'b1;
      end else begin
        div_r <= '0;
      end
    end else if (state_r == ST_STARTUP) begin
      if ((timer_r < TW'(STARTUP_CLKS)) && tick_s) begin
        div_r    <= '0;
        bl_clk_r <= !bl_clk_r;
        if (bl_clk_r) timer_r <= timer_r + 1'b1;
      end else if (timer_r < TW'(STARTUP_CLKS)) begin
        div_r <= div_r + 1'b1;
      end
    end else if ((state_r == ST_PROG) || (state_r == ST_WAIT_INIT)) begin
      if (timer_r != '1) timer_r <= timer_r + 1'b1;
    end
  end

`ifdef BYTE_CNT_EN
  logic [23:0] bytes_r;
  assign bytes_loaded = bytes_r;

  // Bytes whose last configuration clock has completed, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bytes_r <= 24'd0;
    end else if ((next_state_s == ST_PROG) && (state_r != ST_PROG)) begin
      bytes_r <= 24'd0;
    end else if (stay_load_s && word_end_s && (bytes_r != 24'hFFFFFF)) begin
      bytes_r <= bytes_r + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench: a serial (BUS_W=1) and a parallel (BUS_W=8) loader driven side by side.
module tb_fpga_cfg_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] s_gpio = 2'b00, p_gpio = 2'b00;
  logic       s_init_b = 1'b0, p_init_b = 1'b0, s_done = 1'b0, p_done = 1'b0;
  logic       s_program_b, p_program_b, s_bl_clk, p_bl_clk;
  logic [0:0] s_bl_data;
  logic [7:0] p_bl_data;
  logic       s_busy, p_busy, s_cfg_ok, p_cfg_ok, s_cfg_err, p_cfg_err;
`ifdef BYTE_CNT_EN
  logic [23:0] s_bytes, p_bytes;
`endif

  fpga_cfg_loader_if s_bus ();
  fpga_cfg_loader_if p_bus ();

  int checks = 0;
  int failures = 0;
  int s_rises = 0, p_rises = 0, p_idx = 0, p_bad = 0, p_stalls = 0;
  logic [7:0] s_cap = 8'h00, p_last = 8'h00;
  logic p_chk_en = 1'b0;
  int low, guard, base, mid, bad;

  fpga_cfg_loader #(.BUS_W(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .ftdi(s_bus),
    .ftdi_gpio_0(s_gpio[0]), .ftdi_gpio_1(s_gpio[1]),
    .fpga_program_b(s_program_b), .fpga_init_b(s_init_b), .fpga_done(s_done),
    .fpga_bl_clk(s_bl_clk), .fpga_bl_data(s_bl_data),
    .busy(s_busy), .cfg_ok(s_cfg_ok), .cfg_err(s_cfg_err)
`ifdef BYTE_CNT_EN
    , .bytes_loaded(s_bytes)
`endif
  );

  fpga_cfg_loader #(.BUS_W(8)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .ftdi(p_bus),
    .ftdi_gpio_0(p_gpio[0]), .ftdi_gpio_1(p_gpio[1]),
    .fpga_program_b(p_program_b), .fpga_init_b(p_init_b), .fpga_done(p_done),
    .fpga_bl_clk(p_bl_clk), .fpga_bl_data(p_bl_data),
    .busy(p_busy), .cfg_ok(p_cfg_ok), .cfg_err(p_cfg_err)
`ifdef BYTE_CNT_EN
    , .bytes_loaded(p_bytes)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_byte(input int i);
    logic [7:0] t;
    t = i[7:0];
    return 8'h5A + t;
  endfunction

  always @(posedge s_bl_clk) begin
    s_cap   <= {s_cap[6:0], s_bl_data[0]};
    s_rises <= s_rises + 1;
  end

  always @(posedge p_bl_clk) begin
    p_rises <= p_rises + 1;
    p_last  <= p_bl_data;
    if (p_chk_en) begin
      if (p_bl_data !== exp_byte(p_idx)) p_bad <= p_bad + 1;
      p_idx <= p_idx + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte was taken.
  task automatic send(input bit par, input logic [7:0] b);
    int g;
    logic rdn;
    g = 0;
    if (par) begin p_bus.ftdi_data = b; p_bus.ftdi_rxf_n = 1'b0; end
    else begin s_bus.ftdi_data = b; s_bus.ftdi_rxf_n = 1'b0; end
    rdn = par ? p_bus.ftdi_rd_n : s_bus.ftdi_rd_n;
    while (rdn && g < 200) begin
      if (par) p_stalls++;
      @(negedge clk);
      g++;
      rdn = par ? p_bus.ftdi_rd_n : s_bus.ftdi_rd_n;
    end
    if (g >= 200) check("send_ready_timeout", {31'd0, rdn}, 32'd0);
    @(negedge clk);
    if (par) p_bus.ftdi_rxf_n = 1'b1;
    else s_bus.ftdi_rxf_n = 1'b1;
  endtask

  task automatic do_prog(input int n, input logic [1:0] end_mode);
    p_gpio = 2'b11;
    repeat (n) @(negedge clk);
    p_gpio = end_mode;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_bus.ftdi_data = 8'h00; s_bus.ftdi_rxf_n = 1'b1;
    p_bus.ftdi_data = 8'h00; p_bus.ftdi_rxf_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_program_b", p_program_b, 1);
    check("rst_rd_n", p_bus.ftdi_rd_n, 1);
    check("rst_bl_clk", p_bl_clk, 0);
    check("rst_bl_data", p_bl_data, 0);
    check("rst_flags", {p_busy, p_cfg_ok, p_cfg_err, s_busy, s_cfg_ok, s_cfg_err}, 0);
`ifdef BYTE_CNT_EN
    check("rst_bytes", p_bytes, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {s_program_b, s_bus.ftdi_rd_n, s_busy}, 3'b110);

    // Serial: 40-cycle program pulse, then one byte 0xA5.
    s_gpio = 2'b11;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_program_b === 1'b0) low++;
      if (i == 9) s_init_b = 1'b1;
      if (i == 39) s_gpio = 2'b10;
    end
    @(negedge clk);
    check("s_prog_low_cycles", low, 40);
    check("s_prog_release", s_program_b, 1);
    send(1'b0, 8'hA5);
    check("s_data_before_pop", s_bl_data, 0);
    @(negedge clk);
    check("s_first_bit", s_bl_data, 1);
    check("s_clk_low_first", s_bl_clk, 0);
    @(negedge clk);
    check("s_first_rise", s_bl_clk, 1);
    guard = 0;
    while (s_rises < 8 && guard < 100) begin @(negedge clk); guard++; end
    check("s_rise_count", s_rises, 8);
    check("s_bits_msb_first", s_cap, 8'hA5);
    s_done = 1'b1;
    s_gpio = 2'b00;
    guard = 0;
    while (!s_cfg_ok && guard < 400) begin @(negedge clk); guard++; end
    check("s_cfg_ok", s_cfg_ok, 1);
    check("s_total_rises", s_rises, 72);
    check("s_busy_done", s_busy, 0);

    // Parallel: stream 2048 bytes with rxf_n gaps.
    p_init_b = 1'b1;
    do_prog(40, 2'b10);
    p_chk_en = 1'b1;
    base = p_rises;
    mid = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i != 0 && (i % 100) == 0) repeat (3) @(negedge clk);
      if (i == 20) mid = p_stalls;
      if (i == 1000) p_done = 1'b1;
      send(1'b1, exp_byte(i));
    end
    check("p_early_done_ignored", {p_cfg_ok, p_busy}, 2'b01);
    guard = 0;
    while (p_idx < 2048 && guard < 200) begin @(negedge clk); guard++; end
    repeat (2) @(negedge clk);
    check("p_bytes_seen", p_idx, 2048);
    check("p_bytes_in_order", p_bad, 0);
    check("p_rd_n_backpressure", {31'd0, (p_stalls - mid) > 0}, 1);
`ifdef BYTE_CNT_EN
    check("p_bytes_loaded", p_bytes, 2048);
`endif

    // Startup clocks and DONE.
    p_chk_en = 1'b0;
    p_gpio = 2'b00;
    base = p_rises;
    guard = 0;
    while (!p_cfg_ok && guard < 400) begin @(negedge clk); guard++; end
    check("p_startup_pulses", p_rises - base, 64);
    check("p_done_flags", {p_cfg_ok, p_cfg_err, p_busy, p_bus.ftdi_rd_n, p_bl_clk}, 5'b10010);

    // INIT_B never rises: WAIT_INIT timeout.
    p_init_b = 1'b0;
    do_prog(40, 2'b00);
    check("p_ok_cleared_on_prog", {p_cfg_ok, p_program_b}, 2'b00);
    base = p_rises;
    repeat (4000) @(negedge clk);
    check("p_waiting_init", {p_cfg_err, p_busy}, 2'b01);
    repeat (200) @(negedge clk);
    check("p_init_timeout", {p_cfg_err, p_busy, p_program_b}, 3'b101);
    check("p_no_pulses_in_wait", p_rises - base, 0);

    // INIT_B drops mid-load.
    p_init_b = 1'b1;
    do_prog(40, 2'b10);
    check("p_err_cleared_on_prog", {p_cfg_err, p_busy}, 2'b01);
    for (int i = 0; i < 20; i++) send(1'b1, 8'h10 + i[7:0]);
    p_init_b = 1'b0;
    repeat (3) @(negedge clk);
    check("p_init_low_err", {p_cfg_err, p_busy, p_bus.ftdi_rd_n, p_bl_clk}, 4'b0010 | 4'b1000);
    base = p_rises;
    repeat (10) @(negedge clk);
    check("p_clk_stopped", {p_rises - base, 31'd0} >> 31, {p_bl_clk, 31'd0} >> 31);
    check("p_no_rises_after_err", p_rises - base, 0);
    p_gpio = 2'b11;
    p_init_b = 1'b1;
    @(negedge clk);
    check("p_reprog_clears", {p_cfg_err, p_program_b, p_busy}, 3'b001);
    do_prog(39, 2'b10);
    base = p_rises;
    send(1'b1, 8'h3C);
    guard = 0;
    while ((p_rises - base) < 1 && guard < 50) begin @(negedge clk); guard++; end
    check("p_fifo_flushed", p_last, 8'h3C);

    // Reset asserted during LOAD while bl_clk is high.
    for (int i = 0; i < 4; i++) send(1'b1, 8'h01 + i[7:0]);
    guard = 0;
    while (p_bl_clk !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    check("p_mid_high", p_bl_clk, 1);
    rst_n = 1'b0;
    #1;
    check("p_async_rst_outputs",
          {p_program_b, p_bus.ftdi_rd_n, p_bl_clk, p_bl_data, p_busy, p_cfg_ok, p_cfg_err},
          {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p_bus.ftdi_rd_n !== 1'b1 || p_busy !== 1'b0 || p_bl_clk !== 1'b0) bad++;
    end
    check("p_idle_after_rst", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
